// File: rtl/bp_bus_pkg.sv
// bp_bus_pkg: shared widths, decode addresses and state types for the MCU bus responder
package bp_bus_pkg;
    localparam int MC_DATA_WIDTH = 16;
    localparam int MC_ADD_WIDTH = 6;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [MC_ADD_WIDTH-1:0] FIFO_IN_ADDR = 6'h07;
    localparam logic [MC_ADD_WIDTH-1:0] FIFO_OUT_ADDR = 6'h08;
    typedef enum logic [1:0] {IDLE, WR_HOLD, RD_FETCH, RD_DRIVE} bus_state_t;
    typedef enum logic [1:0] {SRC_REG, SRC_FIFO, SRC_NONE} rd_src_t;
endpackage

// File: rtl/mc_bus_responder_if.sv
// mc_bus_responder_if: MCU-side asynchronous parallel bus, pad side of the responder
interface mc_bus_responder_if;
    import bp_bus_pkg::*;
    logic mc_ce;
    logic mc_oe;
    logic mc_we;
    logic [MC_ADD_WIDTH-1:0] mc_add;
    logic [MC_DATA_WIDTH-1:0] mc_data_in;
    logic [MC_DATA_WIDTH-1:0] mc_data_out;
    logic mc_data_oe;
    modport master (
        output mc_ce, mc_oe, mc_we, mc_add, mc_data_in,
        input  mc_data_out, mc_data_oe
    );
    modport slave (
        input  mc_ce, mc_oe, mc_we, mc_add, mc_data_in,
        output mc_data_out, mc_data_oe
    );
endinterface

// File: rtl/bp_sync.sv
// bp_sync: flop-chain synchroniser, resets to 1 so an unreset bus reads as idle
module bp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= '1;
        else r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/mc_bus_responder.sv
// mc_bus_responder: decodes MCU bus accesses into register strobes and FIFO push/pop,
// and drives read data back to the pads
module mc_bus_responder
    import bp_bus_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    mc_bus_responder_if.slave bus,
    output logic reg_wr,
    output logic reg_rd,
    output logic [MC_ADD_WIDTH-1:0] reg_addr,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
    output logic fifo_in_push,
    output logic [MC_DATA_WIDTH-1:0] fifo_in_data,
    input  logic fifo_in_full,
    output logic fifo_out_pop,
    input  logic [MC_DATA_WIDTH-1:0] fifo_out_data,
    input  logic fifo_out_nempty,
    output logic err_overflow,
    output logic err_underflow,
    output logic err_collision
);
    localparam logic [3:0] FLUSH = 4'(SYNC_STAGES);
    logic ce_s, oe_s, we_s;
    bp_sync #(.STAGES(SYNC_STAGES)) u_ce (.clk(clk), .rst_n(rst_n), .d(bus.mc_ce), .q(ce_s));
    bp_sync #(.STAGES(SYNC_STAGES)) u_oe (.clk(clk), .rst_n(rst_n), .d(bus.mc_oe), .q(oe_s));
    bp_sync #(.STAGES(SYNC_STAGES)) u_we (.clk(clk), .rst_n(rst_n), .d(bus.mc_we), .q(we_s));
    logic wr_act, rd_act;
    assign wr_act = !ce_s && !we_s;
    assign rd_act = !ce_s && !oe_s;
    bus_state_t state;
    rd_src_t rd_src;
    logic wr_first, armed;
    logic [3:0] flush_cnt;
    logic [MC_DATA_WIDTH-1:0] data_out;
    logic data_oe;
    assign bus.mc_data_out = data_out;
    assign bus.mc_data_oe = data_oe;
    assign fifo_in_data = reg_wdata;
    // Accesses are accepted only once the flushed synchronisers have shown an idle bus,
    // so a strobe still held low across reset is not mistaken for a new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd_src <= SRC_REG;
            wr_first <= 1'b0;
            armed <= 1'b0;
            flush_cnt <= '0;
            data_out <= '0;
            data_oe <= 1'b0;
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            reg_addr <= '0;
            reg_wdata <= '0;
            fifo_in_push <= 1'b0;
            fifo_out_pop <= 1'b0;
            err_overflow <= 1'b0;
            err_underflow <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            fifo_in_push <= 1'b0;
            fifo_out_pop <= 1'b0;
            wr_first <= 1'b0;
            if (flush_cnt != FLUSH) flush_cnt <= flush_cnt + 4'd1;
            if (flush_cnt == FLUSH && !wr_act && !rd_act) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && wr_act && rd_act) err_collision <= 1'b1;
                    else if (armed && wr_act) begin
                        reg_addr <= bus.mc_add;
                        reg_wdata <= bus.mc_data_in;
                        wr_first <= 1'b1;
                        state <= WR_HOLD;
                    end else if (armed && rd_act) begin
                        reg_addr <= bus.mc_add;
                        state <= RD_FETCH;
                        if (bus.mc_add != FIFO_OUT_ADDR) begin
                            reg_rd <= 1'b1;
                            rd_src <= SRC_REG;
                        end else if (fifo_out_nempty) begin
                            fifo_out_pop <= 1'b1;
                            rd_src <= SRC_FIFO;
                        end else begin
                            err_underflow <= 1'b1;
                            rd_src <= SRC_NONE;
                        end
                    end
                end
                WR_HOLD: begin
                    if (wr_first && reg_addr == FIFO_IN_ADDR) begin
                        fifo_in_push <= !fifo_in_full;
                        if (fifo_in_full) err_overflow <= 1'b1;
                    end else if (wr_first) reg_wr <= 1'b1;
                    if (!wr_act) state <= IDLE;
                end
                RD_FETCH: begin
                    if (!rd_act) state <= IDLE;
                    else begin
                        data_out <= rd_src == SRC_FIFO ? fifo_out_data :
                                    rd_src == SRC_REG  ? reg_rdata : '0;
                        data_oe <= 1'b1;
                        state <= RD_DRIVE;
                    end
                end
                RD_DRIVE: begin
                    if (!rd_act) begin
                        data_oe <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
